// File: rtl/fmac_prim_win_mon_pkg.sv
`default_nettype none
// ============================================================================
// Package : fmac_prim_pkg
// Brief   : Shared types and helpers for the FMAC primitive window monitor.
// Rev     : 1.0
// ============================================================================
package fmac_prim_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    localparam int unsigned c_CALC_W = 32;

    // Width-generic saturating add: result clamps to 2^size-1.
    function automatic logic [c_CALC_W-1:0] sat_add(
        input logic [c_CALC_W-1:0] a,
        input logic [c_CALC_W-1:0] b,
        input int unsigned         size
    );
        logic [c_CALC_W:0]   sum;
        logic [c_CALC_W-1:0] max;
        max = (c_CALC_W'(1) << size) - c_CALC_W'(1);
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, max}) begin
            return max;
        end
        return sum[c_CALC_W-1:0];
    endfunction

    function automatic logic [c_CALC_W-1:0] popcount(input logic [c_CALC_W-1:0] v);
        logic [c_CALC_W-1:0] n;
        n = '0;
        for (int i = 0; i < c_CALC_W; i++) begin
            n = n + {{(c_CALC_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fmac_prim_win_mon_if.sv
`default_nettype none
// ============================================================================
// Interface : fmac_prim_win_mon_if
// Brief     : Primitive inputs, window control, limits and result outputs.
// Rev       : 1.0
// ============================================================================
interface fmac_prim_win_mon_if #(
    parameter int SIZE  = 8,
    parameter int LANES = 2,
    parameter int NCH   = 4,
    parameter int TW    = 16
);
    logic [NCH-1:0][LANES-1:0] prim_in;
    logic                      auto_mode;
    logic                      start;
    logic                      latch;
    logic [TW-1:0]             win_len;
    logic [NCH-1:0][SIZE-1:0]  llimit;
    logic [NCH-1:0][SIZE-1:0]  ulimit;
    logic [NCH-1:0]            too_few;
    logic [NCH-1:0]            too_many;
    logic                      done;
    logic [NCH-1:0][SIZE-1:0]  cnt_out;
    logic [NCH-1:0]            sat_out;

    modport master (
        output prim_in, auto_mode, start, latch, win_len, llimit, ulimit,
        input  too_few, too_many, done, cnt_out, sat_out
    );

    modport slave (
        input  prim_in, auto_mode, start, latch, win_len, llimit, ulimit,
        output too_few, too_many, done, cnt_out, sat_out
    );
endinterface
`default_nettype wire

// File: rtl/fmac_prim_win_mon_chan.sv
`default_nettype none
// ============================================================================
// Module : fmac_prim_chan
// Brief  : One channel: saturating counter, close-time compare, snapshots.
// Rev    : 1.0
// ============================================================================
module fmac_prim_chan
    import fmac_prim_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int LANES = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [LANES-1:0] prim,
    input  wire logic             cnt_clr,
    input  wire logic             cnt_restart,
    input  wire logic             close,
    input  wire logic [SIZE-1:0]  llimit,
    input  wire logic [SIZE-1:0]  ulimit,
    output logic                  too_few,
    output logic                  too_many,
    output logic                  sat_out,
    output logic [SIZE-1:0]       cnt_out
);
    logic [SIZE-1:0] r_cnt;
    logic [SIZE-1:0] r_cnt_out;
    logic            r_sat_out;
    logic            r_too_few;
    logic            r_too_many;
    logic [SIZE-1:0] w_base;
    logic [SIZE-1:0] w_final;

    // Restart counts from zero so the start cycle's primitives are included.
    always_comb begin
        w_base  = cnt_restart ? '0 : r_cnt;
        w_final = SIZE'(sat_add(c_CALC_W'(w_base), popcount(c_CALC_W'(prim)), SIZE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_cnt_out  <= '0;
            r_sat_out  <= 1'b0;
            r_too_few  <= 1'b0;
            r_too_many <= 1'b0;
        end else begin
            r_cnt      <= cnt_clr ? '0 : w_final;
            r_too_few  <= 1'b0;
            r_too_many <= 1'b0;
            if (close) begin
                r_cnt_out  <= w_final;
                r_sat_out  <= &w_final;
                r_too_few  <= (w_final < llimit);
                r_too_many <= (w_final > ulimit);
            end
        end
    end

    assign cnt_out  = r_cnt_out;
    assign sat_out  = r_sat_out;
    assign too_few  = r_too_few;
    assign too_many = r_too_many;

endmodule
`default_nettype wire

// File: rtl/fmac_prim_win_mon.sv
`default_nettype none
// ============================================================================
// Module : fmac_prim_win_mon
// Brief  : Multi-channel primitive window monitor (FSM, timer, close decode).
// Rev    : 1.0
// ============================================================================
module fmac_prim_win_mon
    import fmac_prim_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int LANES = 2,
    parameter int NCH   = 4,
    parameter int TW    = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    fmac_prim_win_mon_if.slave  bus
);
    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_mode;
    logic [TW-1:0]  r_tmr;
    logic           r_done;
    logic [TW-1:0]  w_eff_len;
    logic           w_tmr_hit;
    logic           w_zero_cyc;
    logic           w_close;
    logic           w_cnt_clr;
    logic           w_cnt_restart;
    logic [NCH-1:0] w_too_few;
    logic [NCH-1:0] w_too_many;
    logic [NCH-1:0] w_sat_out;

    // tmr holds the index of the current window cycle minus one; tmr==0 in ACC
    // marks the zeroing cycle that follows a timer-driven close.
    always_comb begin
        w_eff_len  = (bus.win_len < TW'(2)) ? TW'(2) : bus.win_len;
        w_tmr_hit  = (r_tmr == (w_eff_len - TW'(1)));
        w_zero_cyc = (r_state == ACC) && r_mode && (r_tmr == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (bus.start) w_state_nxt = ACC;
            ACC:  if (w_close && (bus.latch || !r_mode)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_close       = 1'b0;
        w_cnt_clr     = 1'b0;
        w_cnt_restart = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_clr     = !bus.start;
                w_cnt_restart = bus.start;
            end
            ACC: begin
                w_close   = bus.latch || (r_mode && w_tmr_hit);
                w_cnt_clr = w_close || w_zero_cyc;
            end
            default: w_cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr  <= '0;
            r_mode <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_close;
            if (r_state == IDLE) begin
                r_tmr <= bus.start ? TW'(1) : '0;
                if (bus.start) r_mode <= bus.auto_mode;
            end else if (w_close) begin
                r_tmr <= '0;
            end else if (w_zero_cyc) begin
                r_tmr <= TW'(1);
            end else begin
                r_tmr <= r_tmr + TW'(1);
            end
        end
    end

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_chan
            fmac_prim_chan #(
                .SIZE  (SIZE),
                .LANES (LANES)
            ) u_chan (
                .clk         (clk),
                .rst_n       (rst_n),
                .prim        (bus.prim_in[c]),
                .cnt_clr     (w_cnt_clr),
                .cnt_restart (w_cnt_restart),
                .close       (w_close),
                .llimit      (bus.llimit[c]),
                .ulimit      (bus.ulimit[c]),
                .too_few     (w_too_few[c]),
                .too_many    (w_too_many[c]),
                .sat_out     (w_sat_out[c]),
                .cnt_out     (bus.cnt_out[c])
            );
        end
    endgenerate

    assign bus.too_few  = w_too_few;
    assign bus.too_many = w_too_many;
    assign bus.sat_out  = w_sat_out;
    assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fmac_prim_win_mon.sv
`default_nettype none
// ============================================================================
// Module : tb_fmac_prim_win_mon
// Brief  : Directed self-checking bench for fmac_prim_win_mon.
// Rev    : 1.0
// ============================================================================
module tb_fmac_prim_win_mon;
    localparam int c_SIZE  = 8;
    localparam int c_LANES = 2;
    localparam int c_NCH   = 4;
    localparam int c_TW    = 16;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    fmac_prim_win_mon_if #(
        .SIZE(c_SIZE), .LANES(c_LANES), .NCH(c_NCH), .TW(c_TW)
    ) bus ();

    fmac_prim_win_mon #(
        .SIZE(c_SIZE), .LANES(c_LANES), .NCH(c_NCH), .TW(c_TW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.prim_in   = '0;
        bus.auto_mode = 1'b0;
        bus.start     = 1'b0;
        bus.latch     = 1'b0;
        bus.win_len   = 16'd8;
        bus.llimit    = '0;
        bus.ulimit    = '1;

        // Reset state
        repeat (2) tick();
        check("rst_done",     32'(bus.done),     32'h0);
        check("rst_cnt_out",  32'(bus.cnt_out),  32'h0);
        check("rst_sat_out",  32'(bus.sat_out),  32'h0);
        check("rst_too_few",  32'(bus.too_few),  32'h0);
        check("rst_too_many", 32'(bus.too_many), 32'h0);
        rst_n = 1'b1;
        tick();

        // Manual window: ch0 lane 0 for 10 cycles
        bus.llimit[0]  = 8'd12;
        bus.ulimit[0]  = 8'd20;
        bus.prim_in[0] = 2'b01;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (8) begin
            tick();
            check("man_nodone", 32'(bus.done), 32'h0);
        end
        bus.latch = 1'b1;
        tick();
        bus.latch      = 1'b0;
        bus.prim_in[0] = 2'b00;
        check("man_done",     32'(bus.done),       32'h1);
        check("man_cnt0",     32'(bus.cnt_out[0]), 32'd10);
        check("man_too_few",  32'(bus.too_few),    32'b0001);
        check("man_too_many", 32'(bus.too_many),   32'b0000);
        tick();
        check("man_done_pulse", 32'(bus.done),       32'h0);
        check("man_cnt0_held",  32'(bus.cnt_out[0]), 32'd10);
        check("man_few_pulse",  32'(bus.too_few),    32'h0);

        // Saturation: ch1 both lanes for 200 cycles
        bus.llimit[0]  = 8'd0;
        bus.ulimit[0]  = 8'hFF;
        bus.ulimit[1]  = 8'd250;
        bus.prim_in[1] = 2'b11;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (198) tick();
        bus.latch = 1'b1;
        tick();
        bus.latch      = 1'b0;
        bus.prim_in[1] = 2'b00;
        check("sat_done",     32'(bus.done),       32'h1);
        check("sat_cnt1",     32'(bus.cnt_out[1]), 32'd255);
        check("sat_cnt0",     32'(bus.cnt_out[0]), 32'd0);
        check("sat_sat_out",  32'(bus.sat_out),    32'b0010);
        check("sat_too_many", 32'(bus.too_many),   32'b0010);
        check("sat_too_few",  32'(bus.too_few),    32'b0000);
        tick();
        bus.ulimit[1] = 8'hFF;

        // Auto mode, win_len=8, ch2 pop=1 every cycle
        bus.auto_mode  = 1'b1;
        bus.win_len    = 16'd8;
        bus.prim_in[2] = 2'b01;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (6) begin
            tick();
            check("auto1_nodone", 32'(bus.done), 32'h0);
        end
        tick();
        check("auto1_done",     32'(bus.done),       32'h1);
        check("auto1_cnt2",     32'(bus.cnt_out[2]), 32'd8);
        check("auto1_too_few",  32'(bus.too_few),    32'h0);
        check("auto1_too_many", 32'(bus.too_many),   32'h0);
        repeat (2) begin
            repeat (7) begin
                tick();
                check("auto_nodone", 32'(bus.done), 32'h0);
            end
            tick();
            check("auto_done", 32'(bus.done),       32'h1);
            check("auto_cnt2", 32'(bus.cnt_out[2]), 32'd7);
        end

        // Latch coincides with timer expiry: one close, back to IDLE
        repeat (7) begin
            tick();
            check("coin_nodone", 32'(bus.done), 32'h0);
        end
        bus.latch = 1'b1;
        tick();
        bus.latch = 1'b0;
        check("coin_done", 32'(bus.done),       32'h1);
        check("coin_cnt2", 32'(bus.cnt_out[2]), 32'd7);
        repeat (20) begin
            tick();
            check("coin_idle_nodone", 32'(bus.done), 32'h0);
        end
        check("coin_cnt2_held", 32'(bus.cnt_out[2]), 32'd7);

        // win_len=1 behaves as 2
        bus.win_len = 16'd1;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("wl1_done1", 32'(bus.done),       32'h1);
        check("wl1_cnt1",  32'(bus.cnt_out[2]), 32'd2);
        tick();
        check("wl1_gap",   32'(bus.done),       32'h0);
        tick();
        check("wl1_done2", 32'(bus.done),       32'h1);
        check("wl1_cnt2",  32'(bus.cnt_out[2]), 32'd1);
        bus.latch = 1'b1;
        tick();
        bus.latch = 1'b0;
        check("wl1_stop_done", 32'(bus.done), 32'h1);
        bus.auto_mode  = 1'b0;
        bus.prim_in[2] = 2'b00;
        repeat (5) begin
            tick();
            check("wl1_idle_nodone", 32'(bus.done), 32'h0);
        end

        // Start+latch together in IDLE, latch 3 cycles later; llimit > ulimit
        bus.llimit[3]  = 8'd9;
        bus.ulimit[3]  = 8'd7;
        bus.prim_in[3] = 2'b11;
        bus.start      = 1'b1;
        bus.latch      = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.latch = 1'b0;
        check("sl_nodone_a", 32'(bus.done), 32'h0);
        tick();
        check("sl_nodone_b", 32'(bus.done), 32'h0);
        tick();
        bus.latch = 1'b1;
        tick();
        bus.latch      = 1'b0;
        bus.prim_in[3] = 2'b00;
        check("sl_done",     32'(bus.done),       32'h1);
        check("sl_cnt3",     32'(bus.cnt_out[3]), 32'd8);
        check("sl_too_few",  32'(bus.too_few),    32'b1000);
        check("sl_too_many", 32'(bus.too_many),   32'b1000);
        bus.llimit[3] = 8'd0;
        bus.ulimit[3] = 8'hFF;
        tick();

        // Reset mid-window after 5 counted cycles
        bus.prim_in[0] = 2'b01;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_done",     32'(bus.done),     32'h0);
        check("mrst_cnt_out",  32'(bus.cnt_out),  32'h0);
        check("mrst_sat_out",  32'(bus.sat_out),  32'h0);
        check("mrst_too_few",  32'(bus.too_few),  32'h0);
        check("mrst_too_many", 32'(bus.too_many), 32'h0);
        tick();
        rst_n          = 1'b1;
        bus.prim_in[0] = 2'b00;
        repeat (3) begin
            tick();
            check("mrst_nodone", 32'(bus.done), 32'h0);
        end
        bus.prim_in[0] = 2'b11;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
        bus.prim_in[0] = 2'b00;
        bus.latch      = 1'b1;
        tick();
        bus.latch = 1'b0;
        check("post_rst_done", 32'(bus.done),       32'h1);
        check("post_rst_cnt0", 32'(bus.cnt_out[0]), 32'd2);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
